// File: rtl/k2_run_ctrl.sv
// ---------------------------------------------------------------------------
// k2_run_ctrl
//
// Run/halt/single-step controller for a small core with one PC breakpoint.
// It decides each cycle whether the core may advance (core_en) and keeps a
// saturating count of executed cycles.
//
// Ports
//   clk        in   single clock, rising-edge
//   reset      in   synchronous active-high reset
//   start      in   run request (IDLE/HALT -> RUN)
//   halt_req   in   stop request (RUN -> HALT)
//   step_req   in   execute one core cycle, then halt
//   bp_en      in   breakpoint enable
//   bp_addr    in   breakpoint PC value [7:0]
//   pc         in   current core PC [7:0]
//   core_en    out  core PC / register enable
//   state      out  IDLE=00 RUN=01 STEP=10 HALT=11
//   halted     out  high in HALT
//   bp_hit     out  sticky: last halt was caused by the breakpoint
//   step_done  out  one-cycle pulse in the first HALT cycle after STEP
//   cycle_cnt  out  saturating count of cycles with core_en=1 [CNT_W-1:0]
// ---------------------------------------------------------------------------
module k2_run_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    input  logic [7:0]       pc,
    output logic             core_en,
    output logic [1:0]       state,
    output logic             halted,
    output logic             bp_hit,
    output logic             step_done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam logic [1:0] StIdle = 2'b00;
    localparam logic [1:0] StRun  = 2'b01;
    localparam logic [1:0] StStep = 2'b10;
    localparam logic [1:0] StHalt = 2'b11;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [1:0]       state_q, state_d;
    logic             bp_skip_q, bp_skip_d;
    logic             bp_hit_q, bp_hit_d;
    logic             step_done_q, step_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bp_match;

    // bp_skip masks the breakpoint for the first cycle after resuming from
    // HALT, so a core parked on the breakpoint PC can move past it.
    assign bp_match = bp_en & (pc == bp_addr) & ~bp_skip_q;
    assign core_en  = (state_q == StStep) | ((state_q == StRun) & ~bp_match);

    always_comb begin
        state_d     = state_q;
        bp_skip_d   = 1'b0;
        bp_hit_d    = bp_hit_q;
        step_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (step_req) begin
                    state_d = StStep;
                end else if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A breakpoint coinciding with halt_req still reports bp_hit.
                if (halt_req || bp_match) begin
                    state_d  = StHalt;
                    bp_hit_d = bp_match;
                end
            end
            StStep: begin
                state_d     = StHalt;
                bp_hit_d    = 1'b0;
                step_done_d = 1'b1;
            end
            StHalt: begin
                if (halt_req) begin
                    state_d = StHalt;
                end else if (step_req) begin
                    state_d = StStep;
                end else if (start) begin
                    state_d   = StRun;
                    bp_skip_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (core_en && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            bp_skip_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
            step_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            bp_skip_q   <= bp_skip_d;
            bp_hit_q    <= bp_hit_d;
            step_done_q <= step_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign state     = state_q;
    assign halted    = (state_q == StHalt);
    assign bp_hit    = bp_hit_q;
    assign step_done = step_done_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_k2_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_k2_run_ctrl
//
// Scoreboard bench: each stimulus cycle pushes the reference model's
// expected outputs into a queue; an independent monitor pops and compares
// them against two DUT instances (CNT_W=16 and CNT_W=4) driven identically.
// ---------------------------------------------------------------------------
module tb_k2_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, halt_req, step_req, bp_en;
    logic [7:0] bp_addr, pc;

    logic        core_en_a, halted_a, bp_hit_a, step_done_a;
    logic [1:0]  state_a;
    logic [15:0] cnt_a;
    logic        core_en_b, halted_b, bp_hit_b, step_done_b;
    logic [1:0]  state_b;
    logic [3:0]  cnt_b;

    k2_run_ctrl #(.CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .core_en(core_en_a), .state(state_a), .halted(halted_a),
        .bp_hit(bp_hit_a), .step_done(step_done_a), .cycle_cnt(cnt_a)
    );

    k2_run_ctrl #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req),
        .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
        .core_en(core_en_b), .state(state_b), .halted(halted_b),
        .bp_hit(bp_hit_b), .step_done(step_done_b), .cycle_cnt(cnt_b)
    );

    typedef struct {
        logic [1:0]  st;
        logic        en;
        logic        hlt;
        logic        hit;
        logic        sd;
        logic [31:0] c16;
        logic [31:0] c4;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;

    // Staged stimulus; copied onto the DUT pins only at the falling edge.
    logic       s_reset = 1'b1, s_start = 1'b0, s_halt = 1'b0, s_step = 1'b0;
    logic       s_bp_en = 1'b0;
    logic [7:0] s_bp_addr = 8'h00, s_pc = 8'h00;
    bit         pc_follow = 1'b1;

    // Reference model: mode 0 idle, 1 run, 2 step, 3 halt; 'total' is the
    // unbounded executed-cycle count, clipped per counter width on output.
    int          m = 0;
    bit          skip = 0, hit = 0, sdone = 0, mvalid = 0;
    int unsigned total = 0;

    function automatic logic [31:0] clip(input int unsigned v, input int unsigned w);
        int unsigned mx = (32'd1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit   match, en;
        exp_t e;
        @(negedge clk);
        reset    = s_reset;
        start    = s_start;
        halt_req = s_halt;
        step_req = s_step;
        bp_en    = s_bp_en;
        bp_addr  = s_bp_addr;
        pc       = s_pc;

        match = s_bp_en && (s_pc == s_bp_addr) && !skip;
        en    = (m == 2) || (m == 1 && !match);
        if (mvalid) begin
            e.st  = 2'(m);
            e.en  = en;
            e.hlt = (m == 3);
            e.hit = hit;
            e.sd  = sdone;
            e.c16 = clip(total, 16);
            e.c4  = clip(total, 4);
            q.push_back(e);
        end

        if (s_reset) begin
            m = 0; skip = 0; hit = 0; sdone = 0; total = 0; mvalid = 1;
        end else begin
            total += en;
            sdone  = (m == 2);
            skip   = 0;
            case (m)
                0: m = s_halt ? 3 : s_step ? 2 : s_start ? 1 : 0;
                1: if (s_halt || match) begin m = 3; hit = match; end
                2: begin m = 3; hit = 0; end
                default: begin
                    if (!s_halt && s_step) m = 2;
                    else if (!s_halt && s_start) begin m = 1; skip = 1; end
                end
            endcase
            if (pc_follow && en) s_pc = s_pc + 8'd1;
        end
    endtask

    // Monitor: outputs are stable every cycle, so one entry per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",       32'(state_a),     32'(e.st));
                chk("core_en",     32'(core_en_a),   32'(e.en));
                chk("halted",      32'(halted_a),    32'(e.hlt));
                chk("bp_hit",      32'(bp_hit_a),    32'(e.hit));
                chk("step_done",   32'(step_done_a), 32'(e.sd));
                chk("cycle_cnt",   32'(cnt_a),       e.c16);
                chk("cycle_cnt_w4", 32'(cnt_b),      e.c4);
                chk("state_w4",    32'(state_b),     32'(e.st));
            end
        end
    end

    initial begin
        // Reset, then run with free-running pc and no breakpoint.
        tick(); tick();
        s_reset = 0; s_pc = 8'h00;
        s_start = 1; tick(); s_start = 0;
        repeat (6) tick();

        // Breakpoint at 0x04 halts before executing it, then resume past it.
        s_reset = 1; tick(); s_reset = 0;
        s_pc = 8'h00; s_bp_en = 1; s_bp_addr = 8'h04;
        s_start = 1; tick(); s_start = 0;
        repeat (8) tick();
        s_start = 1; tick(); s_start = 0;
        repeat (3) tick();

        // Halt, then single step.
        s_halt = 1; tick(); s_halt = 0; tick();
        s_step = 1; tick(); s_step = 0;
        repeat (3) tick();

        // All three requests in IDLE: halt wins.
        s_reset = 1; tick(); s_reset = 0;
        s_start = 1; s_step = 1; s_halt = 1; tick();
        s_start = 0; s_step = 0; s_halt = 0;
        tick(); tick();

        // Reset mid-run.
        s_bp_en = 0;
        s_start = 1; tick(); s_start = 0;
        repeat (4) tick();
        s_reset = 1; tick(); s_reset = 0; tick();

        // Long run: the 4-bit counter saturates at 15.
        s_start = 1; tick(); s_start = 0;
        repeat (22) tick();

        // Reset while in STEP drops the pending step_done.
        s_halt = 1; tick(); s_halt = 0;
        s_step = 1; tick(); s_step = 0;
        s_reset = 1; tick(); s_reset = 0;
        tick(); tick();

        // Randomized traffic over a small PC window so breakpoints fire.
        for (int i = 0; i < 3000; i++) begin
            s_reset = ($urandom_range(0, 99) == 0);
            s_halt  = ($urandom_range(0, 15) == 0);
            s_step  = ($urandom_range(0, 7) == 0);
            s_start = ($urandom_range(0, 3) == 0);
            s_bp_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) s_bp_addr = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) s_pc = 8'($urandom_range(0, 15));
            s_pc = s_pc & 8'h0f;
            tick();
        end

        s_reset = 0; s_start = 0; s_halt = 0; s_step = 0;
        tick(); tick();
        @(negedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
